// File: rtl/atm_transaction_ctrl_if.sv
// Bundle between the ATM session controller and the card-handling/user side.
// The master drives card and request signals; the slave is the controller.
interface atm_transaction_ctrl_if #(
  parameter int unsigned BalanceWidth = 20
);
  logic                    card_in;
  logic                    psw_entered;
  logic                    wrong_psw;
  logic [BalanceWidth-1:0] balance;
  logic                    op_valid;
  logic [1:0]              op_sel;
  logic [BalanceWidth-1:0] amount;
  logic                    op_done;
  logic [BalanceWidth-1:0] updated_balance;
  logic [BalanceWidth-1:0] balance_disp;
  logic                    op_err;
  logic                    locked;
  logic                    card_out;
  logic                    authed;

  modport master (
    output card_in, psw_entered, wrong_psw, balance, op_valid, op_sel, amount,
    input  op_done, updated_balance, balance_disp, op_err, locked, card_out, authed
  );

  modport slave (
    input  card_in, psw_entered, wrong_psw, balance, op_valid, op_sel, amount,
    output op_done, updated_balance, balance_disp, op_err, locked, card_out, authed
  );
endinterface

// File: rtl/atm_transaction_ctrl.sv
// ATM session controller: card insertion, password retries with lockout, operation menu,
// balance arithmetic, idle timeout and card ejection.
module atm_transaction_ctrl #(
  parameter int unsigned BalanceWidth  = 20,
  parameter int unsigned MaxTries      = 3,
  parameter int unsigned TimeoutCycles = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  atm_transaction_ctrl_if.slave bus
);

  localparam int unsigned TryW = $clog2(MaxTries + 1);
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    StIdle, StAuthWait, StAuthCheck, StMenu, StExec, StCommit, StEject
  } state_e;

  state_e                  r_state, w_state_d;
  logic [TryW-1:0]         r_tries, w_tries_d;
  logic [TmoW-1:0]         r_tmo, w_tmo_d;
  logic [1:0]              r_op_sel, w_op_sel_d;
  logic [BalanceWidth-1:0] r_amount, w_amount_d;
  logic [BalanceWidth-1:0] r_upd, w_upd_d;
  logic [BalanceWidth-1:0] r_disp, w_disp_d;
  logic                    r_locked, w_locked_d;
  logic                    r_eject_first, w_eject_first_d;
  logic                    w_op_err;

  // Sum carries one extra bit so the overflow test is just the carry.
  logic [BalanceWidth:0]   w_sum;
  logic                    w_dep_err, w_wd_err, w_tmo_hit;
  logic [TryW-1:0]         w_tries_inc;

  assign w_sum       = {1'b0, bus.balance} + {1'b0, r_amount};
  assign w_dep_err   = (r_amount == '0) || w_sum[BalanceWidth];
  assign w_wd_err    = (r_amount == '0) || (r_amount > bus.balance);
  assign w_tmo_hit   = (r_tmo == TmoW'(TimeoutCycles - 1));
  assign w_tries_inc = r_tries + TryW'(1);

  always_comb begin
    w_state_d  = r_state;
    w_tries_d  = r_tries;
    w_tmo_d    = '0;
    w_op_sel_d = r_op_sel;
    w_amount_d = r_amount;
    w_upd_d    = r_upd;
    w_disp_d   = r_disp;
    w_locked_d = 1'b0;
    w_op_err   = 1'b0;
    case (r_state)
      StIdle: begin
        w_tries_d = '0;
        if (bus.card_in) w_state_d = StAuthWait;
      end
      StAuthWait: begin
        if (!bus.card_in)         w_state_d = StIdle;
        else if (bus.psw_entered) w_state_d = StAuthCheck;
        else if (w_tmo_hit)       w_state_d = StEject;
        else                      w_tmo_d   = r_tmo + TmoW'(1);
      end
      StAuthCheck: begin
        if (!bus.card_in) begin
          w_state_d = StIdle;
        end else if (!bus.wrong_psw) begin
          w_state_d = StMenu;
          w_tries_d = '0;
        end else begin
          w_tries_d = w_tries_inc;
          if (w_tries_inc == TryW'(MaxTries)) begin
            w_locked_d = 1'b1;
            w_state_d  = StEject;
          end else begin
            w_state_d = StAuthWait;
          end
        end
      end
      StMenu: begin
        if (!bus.card_in) begin
          w_state_d = StIdle;
        end else if (bus.op_valid) begin
          w_op_sel_d = bus.op_sel;
          w_amount_d = bus.amount;
          w_state_d  = StExec;
        end else if (w_tmo_hit) begin
          w_state_d = StEject;
        end else begin
          w_tmo_d = r_tmo + TmoW'(1);
        end
      end
      StExec: begin
        // A pulled card aborts the whole transaction, error pulse included.
        if (!bus.card_in) begin
          w_state_d = StIdle;
        end else begin
          unique case (r_op_sel)
            2'b00: begin
              w_disp_d  = bus.balance;
              w_state_d = StMenu;
            end
            2'b01: begin
              if (w_dep_err) begin
                w_op_err  = 1'b1;
                w_state_d = StMenu;
              end else begin
                w_upd_d   = w_sum[BalanceWidth-1:0];
                w_state_d = StCommit;
              end
            end
            2'b10: begin
              if (w_wd_err) begin
                w_op_err  = 1'b1;
                w_state_d = StMenu;
              end else begin
                w_upd_d   = bus.balance - r_amount;
                w_state_d = StCommit;
              end
            end
            2'b11: w_state_d = StEject;
          endcase
        end
      end
      StCommit: begin
        w_disp_d  = r_upd;
        w_state_d = bus.card_in ? StMenu : StIdle;
      end
      StEject: begin
        if (!bus.card_in) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    w_eject_first_d = (w_state_d == StEject) && (r_state != StEject);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_tries       <= '0;
      r_tmo         <= '0;
      r_op_sel      <= 2'b00;
      r_amount      <= '0;
      r_upd         <= '0;
      r_disp        <= '0;
      r_locked      <= 1'b0;
      r_eject_first <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_tries       <= w_tries_d;
      r_tmo         <= w_tmo_d;
      r_op_sel      <= w_op_sel_d;
      r_amount      <= w_amount_d;
      r_upd         <= w_upd_d;
      r_disp        <= w_disp_d;
      r_locked      <= w_locked_d;
      r_eject_first <= w_eject_first_d;
    end
  end

  assign bus.op_done         = (r_state == StCommit);
  assign bus.op_err          = w_op_err;
  assign bus.locked          = r_locked;
  assign bus.card_out        = (r_state == StEject) && r_eject_first;
  assign bus.authed          = (r_state == StMenu) || (r_state == StExec) ||
                               (r_state == StCommit);
  assign bus.updated_balance = r_upd;
  assign bus.balance_disp    = r_disp;

endmodule

// File: tb/tb_atm_transaction_ctrl.sv
// Randomised session bench for atm_transaction_ctrl; the driver knows the session flow and
// sets per-cycle expected outputs, a negedge process compares them against the DUT.
module tb_atm_transaction_ctrl;
  localparam int unsigned BW = 20;
  localparam int unsigned T  = 1000;
  localparam logic [63:0] MaxBal = 64'd1048575;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  atm_transaction_ctrl_if #(.BalanceWidth(BW)) bus ();

  atm_transaction_ctrl #(
    .BalanceWidth (BW),
    .MaxTries     (3),
    .TimeoutCycles(T)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  logic          e_op_done, e_op_err, e_locked, e_card_out, e_authed;
  logic [BW-1:0] e_upd, e_disp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("op_done", bus.op_done, e_op_done);
      check("op_err", bus.op_err, e_op_err);
      check("locked", bus.locked, e_locked);
      check("card_out", bus.card_out, e_card_out);
      check("authed", bus.authed, e_authed);
      check("updated_balance", bus.updated_balance, e_upd);
      check("balance_disp", bus.balance_disp, e_disp);
    end
  end

  // Advance one cycle; pulse inputs and pulse expectations fall back to 0.
  task automatic step();
    @(posedge clk);
    #1;
    bus.psw_entered = 1'b0;
    bus.op_valid    = 1'b0;
    bus.wrong_psw   = 1'($urandom);
    e_op_done       = 1'b0;
    e_op_err        = 1'b0;
    e_locked        = 1'b0;
    e_card_out      = 1'b0;
  endtask

  // Idle cycles with noise on the request line that the current state must ignore.
  task automatic idle(input int k, input bit in_menu);
    repeat (k) begin
      if (in_menu) bus.psw_entered = 1'($urandom);
      else         bus.op_valid    = 1'($urandom);
      bus.op_sel  = 2'($urandom);
      bus.amount  = BW'($urandom);
      bus.balance = BW'($urandom);
      step();
    end
  endtask

  task automatic auth_ok();
    bus.card_in = 1'b1;
    step();
    bus.psw_entered = 1'b1;
    step();
    bus.wrong_psw = 1'b0;
    step();
    e_authed = 1'b1;
  endtask

  // Called in the first EJECT cycle; waits a little, then pulls the card.
  task automatic remove_card(input bit poke);
    repeat ($urandom % 4) begin
      if (poke) bus.psw_entered = 1'b1;
      step();
    end
    bus.card_in = 1'b0;
    step();
  endtask

  // One menu operation starting in a MENU cycle. ret: 0 back in MENU, 1 card pulled, 2 ejecting.
  task automatic op(input logic [1:0] sel, input logic [63:0] amt, input logic [63:0] bal,
                    input bit pull, output int ret);
    logic [63:0] res;
    bit          err;
    ret = 0;
    res = 64'd0;
    err = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_sel   = sel;
    bus.amount   = amt[BW-1:0];
    bus.balance  = bal[BW-1:0];
    step();
    bus.op_sel = 2'($urandom);
    bus.amount = BW'($urandom);
    if (pull) begin
      bus.card_in = 1'b0;
      step();
      e_authed = 1'b0;
      ret = 1;
      return;
    end
    case (sel)
      2'b01: begin res = bal + amt; err = (amt == 0) || (res > MaxBal); end
      2'b10: begin res = bal - amt; err = (amt == 0) || (amt > bal); end
      default: ;
    endcase
    if (sel == 2'b00) begin
      step();
      e_disp = bal[BW-1:0];
    end else if (sel == 2'b11) begin
      step();
      e_authed   = 1'b0;
      e_card_out = 1'b1;
      ret = 2;
    end else if (err) begin
      e_op_err = 1'b1;
      step();
    end else begin
      step();
      e_upd     = res[BW-1:0];
      e_op_done = 1'b1;
      step();
      e_disp = res[BW-1:0];
    end
  endtask

  task automatic session();
    int          tries;
    int          ret;
    bit          w;
    logic [63:0] bal, amt;
    logic [1:0]  sel;
    tries = 0;
    bus.card_in = 1'b1;
    step();
    while (!e_authed) begin
      idle($urandom % 3, 1'b0);
      w = ($urandom % 2) == 0;
      bus.psw_entered = 1'b1;
      step();
      bus.wrong_psw = w;
      step();
      if (!w) begin
        e_authed = 1'b1;
        tries = 0;
      end else begin
        tries++;
        if (tries == 3) begin
          e_locked   = 1'b1;
          e_card_out = 1'b1;
          remove_card(1'b1);
          return;
        end
      end
    end
    repeat (1 + $urandom % 6) begin
      idle($urandom % 4, 1'b1);
      sel = 2'($urandom % 3);
      bal = ($urandom % 4 == 0) ? 64'($urandom % 1000) : (64'($urandom) & MaxBal);
      case ($urandom % 7)
        0: amt = 0;
        1: amt = 64'($urandom % 1000);
        2: amt = bal;
        3: amt = bal + 1;
        4: amt = MaxBal - bal;
        5: amt = MaxBal - bal + 1;
        default: amt = 64'($urandom);
      endcase
      amt = amt & MaxBal;
      op(sel, amt, bal, ($urandom % 10) == 0, ret);
      if (ret == 1) return;
    end
    op(2'b11, 64'd0, 64'd0, 1'b0, ret);
    remove_card(1'b0);
  endtask

  initial begin
    int ret;
    rst_n           = 1'b0;
    bus.card_in     = 1'b0;
    bus.psw_entered = 1'b0;
    bus.wrong_psw   = 1'b0;
    bus.balance     = '0;
    bus.op_valid    = 1'b0;
    bus.op_sel      = 2'b00;
    bus.amount      = '0;
    e_op_done = 0; e_op_err = 0; e_locked = 0; e_card_out = 0; e_authed = 0;
    e_upd = '0; e_disp = '0;
    chk_en = 1'b1;
    // Reset with random inputs: every output must stay 0.
    repeat (6) begin
      step();
      bus.card_in     = 1'($urandom);
      bus.psw_entered = 1'($urandom);
      bus.op_valid    = 1'($urandom);
      bus.op_sel      = 2'($urandom);
      bus.amount      = BW'($urandom);
      bus.balance     = BW'($urandom);
    end
    step();
    bus.card_in = 1'b0;
    rst_n = 1'b1;
    step();

    // Lockout: three wrong passwords, then an ignored fourth attempt in EJECT.
    bus.card_in = 1'b1;
    step();
    repeat (3) begin
      bus.psw_entered = 1'b1;
      step();
      bus.wrong_psw = 1'b1;
      step();
    end
    e_locked   = 1'b1;
    e_card_out = 1'b1;
    check("lit_lock_card_out", bus.card_out, 1);
    bus.psw_entered = 1'b1;
    step();
    step();
    bus.card_in = 1'b0;
    step();

    // Withdraw and deposit boundaries with literal expectations.
    auth_ok();
    op(2'b10, 64'd200, 64'd500, 1'b0, ret);
    check("lit_wd_upd", bus.updated_balance, 300);
    check("lit_wd_disp", bus.balance_disp, 300);
    op(2'b10, 64'd501, 64'd500, 1'b0, ret);
    check("lit_wd_err_upd", bus.updated_balance, 300);
    op(2'b01, 64'd10, 64'd1048570, 1'b0, ret);
    check("lit_dep_ovf_upd", bus.updated_balance, 300);
    op(2'b01, 64'd5, 64'd1048570, 1'b0, ret);
    check("lit_dep_max_upd", bus.updated_balance, 1048575);
    op(2'b00, 64'd0, 64'd777, 1'b0, ret);
    check("lit_inq_disp", bus.balance_disp, 777);
    op(2'b11, 64'd0, 64'd0, 1'b0, ret);
    remove_card(1'b0);

    // Card pulled during EXEC of a withdraw.
    auth_ok();
    op(2'b10, 64'd100, 64'd500, 1'b1, ret);
    check("lit_pull_upd", bus.updated_balance, 1048575);
    step();

    // Idle timeout in MENU.
    auth_ok();
    repeat (T) step();
    e_authed   = 1'b0;
    e_card_out = 1'b1;
    check("lit_tmo_card_out", bus.card_out, 1);
    remove_card(1'b0);

    repeat (40) session();

    // Reset asserted during EXEC aborts the commit.
    auth_ok();
    bus.op_valid = 1'b1;
    bus.op_sel   = 2'b10;
    bus.amount   = BW'(100);
    bus.balance  = BW'(500);
    step();
    rst_n = 1'b0;
    bus.card_in = 1'b0;
    e_upd = '0; e_disp = '0; e_authed = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
